rsa_modexp_ctrl: RTL

//  Sequencing stage directly upstream of the 1024-bit Montgomery multiplier.

---
 rtl/rsa_modexp_ctrl_pkg.sv | 28 ++
 rtl/rsa_modexp_ctrl_mm_port_seq.sv | 66 ++++++
 rtl/rsa_modexp_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and the RSA top level:
// default widths and the two-level FSM encoding (operation x multiplier-port phase).
package rsa_modexp_ctrl_pkg;

   localparam int DEF_WIDTH = 1024;
   localparam int DEF_EXP_W = 1024;
   localparam int DEF_LEN_W = 11;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_TOMONT,
      OP_SQUARE,
      OP_MULT,
      OP_FROMMONT
   } op_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_ISSUE,
      PH_WAIT
   } phase_t;

   typedef struct packed {
      op_t    op;
      phase_t phase;
   } state_t;

endpackage

// File: rtl/rsa_modexp_ctrl_mm_port_seq.sv
// One Montgomery product over the multiplier start/done port: issue, wait, capture.
// A product is requested by a 1-cycle go pulse and answered by a 1-cycle ack pulse.
module mm_port_seq
   import rsa_modexp_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   input  logic [WIDTH-1:0] mm_result,
   input  logic             mm_done,
   output logic             ack,
   output logic [WIDTH-1:0] prod,
   output phase_t           phase
);

   logic blank;

   // mm_start is high for exactly the ISSUE cycle; mm_done is only honoured in WAIT,
   // and never in its first cycle, because the multiplier may still show the previous done.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase    <= PH_IDLE;
         mm_start <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
         ack      <= 1'b0;
         prod     <= '0;
         blank    <= 1'b0;
      end else begin
         mm_start <= 1'b0;
         ack      <= 1'b0;
         case (phase)
            PH_IDLE: begin
               if (go) begin
                  mm_a     <= a;
                  mm_b     <= b;
                  mm_start <= 1'b1;
                  phase    <= PH_ISSUE;
               end
            end
            PH_ISSUE: begin
               blank <= 1'b1;
               phase <= PH_WAIT;
            end
            PH_WAIT: begin
               if (blank) begin
                  blank <= 1'b0;
               end else if (mm_done) begin
                  prod  <= mm_result;
                  ack   <= 1'b1;
                  phase <= PH_IDLE;
               end
            end
            default: phase <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer in front of the Montgomery multiplier:
// enters the Montgomery domain with x*R^2, scans e by a down-counter, leaves with A*1.
module rsa_modexp_ctrl
   import rsa_modexp_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int EXP_W = DEF_EXP_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in_x,
   input  logic [EXP_W-1:0] in_e,
   input  logic [LEN_W-1:0] in_e_len,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_r2,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   output logic [WIDTH-1:0] mm_m,
   input  logic [WIDTH-1:0] mm_result,
   input  logic             mm_done,
   output state_t           state
);

   localparam int               IDX_W   = $clog2(EXP_W);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_W);

   op_t              op;
   phase_t           phase;
   logic [EXP_W-1:0] e_q;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_dec;
   logic [IDX_W-1:0] bit_idx;
   logic             e_bit;
   logic [WIDTH-1:0] xm;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] prod;
   logic             go;
   logic             ack;

   always_comb begin
      cnt_dec = cnt - LEN_W'(1);
      bit_idx = IDX_W'(cnt_dec);
      e_bit   = e_q[bit_idx];
   end

   assign state = '{op: op, phase: phase};

   mm_port_seq #(.WIDTH(WIDTH)) u_seq (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .a         (op_a),
      .b         (op_b),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_result (mm_result),
      .mm_done   (mm_done),
      .ack       (ack),
      .prod      (prod),
      .phase     (phase)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         op     <= OP_IDLE;
         e_q    <= '0;
         cnt    <= '0;
         xm     <= '0;
         acc    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         go     <= 1'b0;
         mm_m   <= '0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         go   <= 1'b0;
         done <= 1'b0;
         case (op)
            OP_IDLE: begin
               // The done cycle is spent in IDLE with busy still high; start is refused there.
               if (done) begin
                  busy <= 1'b0;
               end else if (start) begin
                  e_q  <= in_e;
                  mm_m <= in_m;
                  acc  <= in_r;
                  cnt  <= (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;
                  op_a <= in_x;
                  op_b <= in_r2;
                  go   <= 1'b1;
                  busy <= 1'b1;
                  op   <= OP_TOMONT;
               end
            end
            OP_TOMONT: begin
               if (ack) begin
                  xm   <= prod;
                  go   <= 1'b1;
                  op_a <= acc;
                  if (cnt == '0) begin
                     op_b <= ONE;
                     op   <= OP_FROMMONT;
                  end else begin
                     op_b <= acc;
                     op   <= OP_SQUARE;
                  end
               end
            end
            OP_SQUARE: begin
               if (ack) begin
                  acc  <= prod;
                  go   <= 1'b1;
                  op_a <= prod;
                  if (e_bit) begin
                     op_b <= xm;
                     op   <= OP_MULT;
                  end else begin
                     cnt  <= cnt_dec;
                     op_b <= (cnt_dec == '0) ? ONE : prod;
                     op   <= (cnt_dec == '0) ? OP_FROMMONT : OP_SQUARE;
                  end
               end
            end
            OP_MULT: begin
               if (ack) begin
                  acc  <= prod;
                  go   <= 1'b1;
                  op_a <= prod;
                  cnt  <= cnt_dec;
                  op_b <= (cnt_dec == '0) ? ONE : prod;
                  op   <= (cnt_dec == '0) ? OP_FROMMONT : OP_SQUARE;
               end
            end
            OP_FROMMONT: begin
               if (ack) begin
                  result <= prod;
                  done   <= 1'b1;
                  op     <= OP_IDLE;
               end
            end
            default: op <= OP_IDLE;
         endcase
      end
   end

endmodule
